// File: rtl/branch_target_cache_if.sv
// Search/update bus of the branch target cache.
// The cache drives the o* response signals; the fetch/resolve side drives the i* request signals.
interface branch_target_cache_if;
    logic        iSEARCH_STB;
    logic [31:0] iSEARCH_INST_ADDR;
    logic        oSEARCH_VALID;
    logic        oSEARCH_HIT;
    logic        oSEARCH_PREDICT_BRANCH;
    logic [31:0] oSEARCH_ADDR;
    logic        iJUMP_STB;
    logic        iJUMP_HIT;
    logic [31:0] iJUMP_ADDR;
    logic [31:0] iJUMP_INST_ADDR;

    modport master (
        output iSEARCH_STB, iSEARCH_INST_ADDR, iJUMP_STB, iJUMP_HIT, iJUMP_ADDR, iJUMP_INST_ADDR,
        input  oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR
    );

    modport slave (
        input  iSEARCH_STB, iSEARCH_INST_ADDR, iJUMP_STB, iJUMP_HIT, iJUMP_ADDR, iJUMP_INST_ADDR,
        output oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR
    );
endinterface

// File: rtl/branch_target_cache.sv
// Set-associative branch target cache with 2-bit taken counters and age-based LRU replacement.
// Lookups are registered (1-cycle latency); updates from branch resolution allocate only on taken.
module branch_target_cache #(
    parameter int SET_N = 8,
    parameter int WAY_N = 4
) (
    input  logic iCLOCK,
    input  logic inRESET,
    input  logic iRESET_SYNC,
    input  logic iFLUSH,
    branch_target_cache_if.slave bus
);
    localparam int IDXW = $clog2(SET_N);
    localparam int AW   = $clog2(WAY_N);
    localparam int TAGW = 30 - IDXW;

    typedef logic [WAY_N-1:0][AW-1:0] age_set_t;
    typedef logic [WAY_N-1:0][1:0]    cnt_set_t;

    logic [WAY_N-1:0] valid_q [SET_N];
    logic [WAY_N-1:0] valid_d [SET_N];
    cnt_set_t         cnt_q   [SET_N];
    cnt_set_t         cnt_d   [SET_N];
    age_set_t         age_q   [SET_N];
    age_set_t         age_d   [SET_N];
    logic [TAGW-1:0]  tag_q   [SET_N][WAY_N];
    logic [31:0]      tgt_q   [SET_N][WAY_N];

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_hit_q, rsp_hit_d;
    logic        rsp_pred_q, rsp_pred_d;
    logic [31:0] rsp_addr_q, rsp_addr_d;

    logic [IDXW-1:0] s_idx, u_idx;
    logic [TAGW-1:0] s_tag, u_tag;
    logic            s_hit, u_hit;
    logic [AW-1:0]   s_way, u_way, v_way, wr_way;
    logic            tag_we, tgt_we;

    // Low two address bits never take part in the lookup.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{bus.iSEARCH_INST_ADDR[1:0], bus.iJUMP_INST_ADDR[1:0]};

    assign s_idx = bus.iSEARCH_INST_ADDR[IDXW+1:2];
    assign s_tag = bus.iSEARCH_INST_ADDR[31:IDXW+2];
    assign u_idx = bus.iJUMP_INST_ADDR[IDXW+1:2];
    assign u_tag = bus.iJUMP_INST_ADDR[31:IDXW+2];

    function automatic age_set_t age_init();
        age_set_t r;
        for (int w = 0; w < WAY_N; w++) r[w] = AW'(w);
        return r;
    endfunction

    // Move way w to most-recent, aging only the ways that were more recent than it.
    function automatic age_set_t touch(age_set_t a, logic [AW-1:0] w);
        age_set_t r;
        r = a;
        for (int i = 0; i < WAY_N; i++)
            if (a[i] < a[w]) r[i] = a[i] + AW'(1);
        r[w] = '0;
        return r;
    endfunction

    always_comb begin
        s_hit = 1'b0;
        s_way = '0;
        u_hit = 1'b0;
        u_way = '0;
        v_way = '0;
        for (int w = 0; w < WAY_N; w++) begin
            if (valid_q[s_idx][w] && tag_q[s_idx][w] == s_tag) begin
                s_hit = 1'b1;
                s_way = AW'(w);
            end
            if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
                u_hit = 1'b1;
                u_way = AW'(w);
            end
            if (age_q[u_idx][w] == AW'(WAY_N-1)) v_way = AW'(w);
        end
        // Invalid ways win over the LRU way; descending scan leaves the lowest index.
        for (int w = WAY_N-1; w >= 0; w--)
            if (!valid_q[u_idx][w]) v_way = AW'(w);
    end

    always_comb begin
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        age_d       = age_q;
        tag_we      = 1'b0;
        tgt_we      = 1'b0;
        wr_way      = u_way;
        rsp_valid_d = 1'b0;
        rsp_hit_d   = 1'b0;
        rsp_pred_d  = 1'b0;
        rsp_addr_d  = '0;
        if (iFLUSH) begin
            for (int s = 0; s < SET_N; s++) begin
                valid_d[s] = '0;
                cnt_d[s]   = '0;
                age_d[s]   = age_init();
            end
        end else begin
            rsp_valid_d = bus.iSEARCH_STB;
            if (bus.iSEARCH_STB && s_hit) begin
                rsp_hit_d  = 1'b1;
                rsp_pred_d = cnt_q[s_idx][s_way][1];
                rsp_addr_d = tgt_q[s_idx][s_way];
                // A concurrent update to the same set owns the age ordering this cycle.
                if (!(bus.iJUMP_STB && u_idx == s_idx))
                    age_d[s_idx] = touch(age_q[s_idx], s_way);
            end
            if (bus.iJUMP_STB) begin
                if (u_hit) begin
                    if (bus.iJUMP_HIT) begin
                        if (cnt_q[u_idx][u_way] != 2'd3)
                            cnt_d[u_idx][u_way] = cnt_q[u_idx][u_way] + 2'd1;
                        tgt_we = 1'b1;
                    end else if (cnt_q[u_idx][u_way] != 2'd0) begin
                        cnt_d[u_idx][u_way] = cnt_q[u_idx][u_way] - 2'd1;
                    end
                    age_d[u_idx] = touch(age_q[u_idx], u_way);
                end else if (bus.iJUMP_HIT) begin
                    wr_way                = v_way;
                    valid_d[u_idx][v_way] = 1'b1;
                    cnt_d[u_idx][v_way]   = 2'd2;
                    tag_we                = 1'b1;
                    tgt_we                = 1'b1;
                    age_d[u_idx]          = touch(age_q[u_idx], v_way);
                end
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int s = 0; s < SET_N; s++) begin
                valid_q[s] <= '0;
                cnt_q[s]   <= '0;
                age_q[s]   <= age_init();
            end
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_pred_q  <= 1'b0;
            rsp_addr_q  <= '0;
        end else if (iRESET_SYNC) begin
            for (int s = 0; s < SET_N; s++) begin
                valid_q[s] <= '0;
                cnt_q[s]   <= '0;
                age_q[s]   <= age_init();
            end
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_pred_q  <= 1'b0;
            rsp_addr_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            age_q       <= age_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_pred_q  <= rsp_pred_d;
            rsp_addr_q  <= rsp_addr_d;
        end
    end

    // Tag and target payload is qualified by valid, so it carries no reset.
    always_ff @(posedge iCLOCK) begin
        if (tag_we && !iRESET_SYNC) tag_q[u_idx][wr_way] <= u_tag;
        if (tgt_we && !iRESET_SYNC) tgt_q[u_idx][wr_way] <= bus.iJUMP_ADDR;
    end

    assign bus.oSEARCH_VALID          = rsp_valid_q;
    assign bus.oSEARCH_HIT            = rsp_hit_q;
    assign bus.oSEARCH_PREDICT_BRANCH = rsp_pred_q;
    assign bus.oSEARCH_ADDR           = rsp_addr_q;
endmodule

// File: tb/tb_branch_target_cache.sv
// Scoreboard bench for branch_target_cache: an LRU-list reference model predicts each search
// response; a negedge monitor pops and compares whenever the cache presents a response.
module tb_branch_target_cache;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rsync = 1'b0;
    logic flush = 1'b0;

    branch_target_cache_if bus();

    branch_target_cache #(.SET_N(8), .WAY_N(4)) dut (
        .iCLOCK     (clk),
        .inRESET    (rst_n),
        .iRESET_SYNC(rsync),
        .iFLUSH     (flush),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          hit;
        bit          pred;
        logic [31:0] addr;
    } exp_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   errs = 0;

    // Reference model: per-set recency list, front = most recently used way.
    bit          mv   [8][4];
    logic [31:0] mtag [8][4];
    logic [31:0] mtgt [8][4];
    int          mcnt [8][4];
    int          lru  [8][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            lru[s].delete();
            for (int w = 0; w < 4; w++) begin
                mv[s][w]   = 1'b0;
                mcnt[s][w] = 0;
                lru[s].push_back(w);
            end
        end
    endtask

    function automatic int find(input int s, input logic [31:0] tag);
        for (int w = 0; w < 4; w++)
            if (mv[s][w] && mtag[s][w] == tag) return w;
        return -1;
    endfunction

    task automatic touch(input int s, input int w);
        for (int i = 0; i < lru[s].size(); i++)
            if (lru[s][i] == w) begin
                lru[s].delete(i);
                break;
            end
        lru[s].push_front(w);
    endtask

    task automatic step(input bit ss, input logic [31:0] sa, input bit js, input bit jh,
                        input logic [31:0] ja, input logic [31:0] ji, input bit fl, input bit rs);
        int   si, sw, ui, uw, v;
        bit   stouch;
        exp_t e;
        bus.iSEARCH_STB       = ss;
        bus.iSEARCH_INST_ADDR = sa;
        bus.iJUMP_STB         = js;
        bus.iJUMP_HIT         = jh;
        bus.iJUMP_ADDR        = ja;
        bus.iJUMP_INST_ADDR   = ji;
        flush                 = fl;
        rsync                 = rs;
        if (rs || fl) begin
            model_reset();
        end else begin
            si     = int'((sa >> 2) & 32'd7);
            sw     = find(si, sa >> 5);
            stouch = 1'b0;
            if (ss) begin
                e.hit  = (sw >= 0);
                e.pred = 1'b0;
                e.addr = '0;
                if (sw >= 0) begin
                    e.pred = (mcnt[si][sw] >= 2);
                    e.addr = mtgt[si][sw];
                end
                sbq.push_back(e);
                stouch = (sw >= 0) && !(js && int'((ji >> 2) & 32'd7) == si);
            end
            if (js) begin
                ui = int'((ji >> 2) & 32'd7);
                uw = find(ui, ji >> 5);
                if (uw >= 0) begin
                    if (jh) begin
                        if (mcnt[ui][uw] < 3) mcnt[ui][uw]++;
                        mtgt[ui][uw] = ja;
                    end else if (mcnt[ui][uw] > 0) begin
                        mcnt[ui][uw]--;
                    end
                    touch(ui, uw);
                end else if (jh) begin
                    v = -1;
                    for (int w = 0; w < 4; w++)
                        if (!mv[ui][w] && v < 0) v = w;
                    if (v < 0) v = lru[ui][lru[ui].size()-1];
                    mv[ui][v]   = 1'b1;
                    mtag[ui][v] = ji >> 5;
                    mtgt[ui][v] = ja;
                    mcnt[ui][v] = 2;
                    touch(ui, v);
                end
            end
            if (stouch) touch(si, sw);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, '0, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic srch(input logic [31:0] a);
        step(1, a, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic jump(input bit taken, input logic [31:0] tgt, input logic [31:0] inst);
        step(0, '0, 1, taken, tgt, inst, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.oSEARCH_VALID === 1'b1) begin
            if (sbq.size() == 0) begin
                nvec++;
                errs++;
                $display("FAIL spurious_valid: got valid=1 expected no response (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                chk("search_hit", {31'd0, bus.oSEARCH_HIT}, {31'd0, e.hit});
                chk("search_predict", {31'd0, bus.oSEARCH_PREDICT_BRANCH}, {31'd0, e.pred});
                chk("search_addr", bus.oSEARCH_ADDR, e.addr);
            end
        end
    end

    initial begin
        logic [31:0] a, b;
        bus.iSEARCH_STB       = 1'b0;
        bus.iSEARCH_INST_ADDR = '0;
        bus.iJUMP_STB         = 1'b0;
        bus.iJUMP_HIT         = 1'b0;
        bus.iJUMP_ADDR        = '0;
        bus.iJUMP_INST_ADDR   = '0;
        model_reset();
        #12;
        chk("reset_valid", {31'd0, bus.oSEARCH_VALID}, 32'd0);
        chk("reset_hit", {31'd0, bus.oSEARCH_HIT}, 32'd0);
        chk("reset_predict", {31'd0, bus.oSEARCH_PREDICT_BRANCH}, 32'd0);
        chk("reset_addr", bus.oSEARCH_ADDR, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Cold miss, allocate, counter walk-down.
        srch(32'h0000_1004);
        jump(1, 32'h0000_2000, 32'h0000_1004);
        srch(32'h0000_1004);
        jump(0, 32'h0, 32'h0000_1004);
        jump(0, 32'h0, 32'h0000_1004);
        srch(32'h0000_1004);
        jump(0, 32'h0, 32'h0000_1004);
        srch(32'h0000_1004);

        // Synchronous reset beats a concurrent search and update.
        step(1, 32'h0000_1004, 1, 1, 32'h0000_0009, 32'h0000_1004, 0, 1);
        srch(32'h0000_1004);

        // Fill set 1, refresh 0x1004, then evict the LRU entry.
        jump(1, 32'h0000_A100, 32'h0000_1004);
        jump(1, 32'h0000_A200, 32'h0000_2004);
        jump(1, 32'h0000_A300, 32'h0000_3004);
        jump(1, 32'h0000_A400, 32'h0000_4004);
        srch(32'h0000_1004);
        jump(1, 32'h0000_A500, 32'h0000_5004);
        srch(32'h0000_2004);
        srch(32'h0000_1004);
        srch(32'h0000_5004);

        // Not-taken miss does not allocate; flush wipes everything.
        jump(0, 32'h0000_B000, 32'h0000_6004);
        srch(32'h0000_6004);
        step(1, 32'h0000_1004, 1, 1, 32'h0000_C000, 32'h0000_7004, 1, 0);
        srch(32'h0000_1004);
        srch(32'h0000_5004);
        srch(32'h0000_7004);

        // Search and update to the same set in one cycle.
        jump(1, 32'h0000_00A0, 32'h0000_1004);
        step(1, 32'h0000_1004, 1, 1, 32'h0000_00B0, 32'h0000_1004, 0, 0);
        srch(32'h0000_1004);
        idle();
        idle();

        // Async reset asserted while a search is in flight suppresses its response.
        bus.iSEARCH_STB       = 1'b1;
        bus.iSEARCH_INST_ADDR = 32'h0000_1004;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", {31'd0, bus.oSEARCH_VALID}, 32'd0);
        chk("async_reset_addr", bus.oSEARCH_ADDR, 32'd0);
        @(posedge clk);
        #1;
        bus.iSEARCH_STB = 1'b0;
        rst_n = 1'b1;
        model_reset();
        chk("post_reset_valid", {31'd0, bus.oSEARCH_VALID}, 32'd0);
        srch(32'h0000_1004);

        for (int n = 0; n < 3000; n++) begin
            a = ($urandom_range(0, 5) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            b = ($urandom_range(0, 5) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            step($urandom_range(0, 9) < 7, a, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6,
                 $urandom(), b, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 1);
        end
        idle();
        idle();
        idle();
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule

// File: doc/branch_target_cache.md
BRANCH_TARGET_CACHE -- requirements
Module: branch_target_cache

Interface
REQ-001 SHALL provide parameter SET_N, default 8, number of sets; power of two, 2..64.
REQ-002 SHALL provide parameter WAY_N, default 4, associativity; legal values 2 or 4.
REQ-003 SHALL provide ports, one per line:
- iCLOCK  in  1  sole clock, rising edge.
- inRESET  in  1  asynchronous active-low reset.
- iRESET_SYNC  in  1  synchronous reset, active high.
- iFLUSH  in  1  synchronous invalidate-all, active high.
- iSEARCH_STB  in  1  search request.
- iSEARCH_INST_ADDR  in  32  fetch address to look up.
- oSEARCH_VALID  out  1  search response valid.
- oSEARCH_HIT  out  1  response hit.
- oSEARCH_PREDICT_BRANCH  out  1  predict taken.
- oSEARCH_ADDR  out  32  predicted target.
- iJUMP_STB  in  1  branch-resolution update.
- iJUMP_HIT  in  1  1 = branch resolved taken.
- iJUMP_ADDR  in  32  resolved target.
- iJUMP_INST_ADDR  in  32  branch instruction address.
REQ-004 SHALL decode addresses as: index = ADDR[IDXW+1:2], tag = ADDR[31:IDXW+2], IDXW = log2(SET_N); ADDR[1:0] ignored.

Function
REQ-005 Each way entry SHALL hold: valid bit, tag, 32-bit target, 2-bit saturating counter (0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T), log2(WAY_N)-bit age.
REQ-006 Ages within a set SHALL always be a permutation of 0..WAY_N-1 (0 = most recent).
REQ-007 Touching way w SHALL set age[w]=0 and increment every age < old age[w]; others unchanged.
REQ-008 Search SHALL be registered: response on the cycle after iSEARCH_STB, 1-cycle latency, no backpressure, one search per cycle.
REQ-009 oSEARCH_VALID SHALL equal iSEARCH_STB delayed one cycle.
REQ-010 Hit SHALL require valid and tag match; at most one way matches; oSEARCH_HIT=0 when valid=0.
REQ-011 On hit, oSEARCH_PREDICT_BRANCH = counter[1], oSEARCH_ADDR = way target; on miss both SHALL be 0.
REQ-012 A search hit SHALL touch the hit way per REQ-007.
REQ-013 Update hit (same decode on iJUMP_INST_ADDR): counter +1 saturating at 3 if iJUMP_HIT, -1 saturating at 0 otherwise; target <= iJUMP_ADDR only if iJUMP_HIT; touch way.
REQ-014 Update miss with iJUMP_HIT=1 SHALL allocate: victim = lowest-index invalid way, else way with age WAY_N-1; write valid=1, tag, target, counter=2; touch victim.
REQ-015 Update miss with iJUMP_HIT=0 SHALL not allocate nor change state.
REQ-016 Search and update same cycle: search response SHALL reflect pre-update contents; if same set, only update's touch applies to ages.
REQ-017 iFLUSH SHALL clear every valid bit, counters to 0, ages to way index, and force oSEARCH_VALID=0 next cycle; concurrent search/update ignored.
REQ-018 Tag, target storage need no reset; valid/counter/age SHALL.

Reset
REQ-019 inRESET low SHALL immediately force: all valid=0, counters=0, age[w]=w, all outputs 0.
REQ-020 iRESET_SYNC SHALL behave identically to inRESET, synchronously, with priority over iFLUSH, search, update.
REQ-021 Reset asserted mid-search SHALL suppress that response (oSEARCH_VALID=0).

Verification (SET_N=8, WAY_N=4)
REQ-022 After reset, search 0x0000_1004 -> next cycle VALID=1, HIT=0, PREDICT=0, ADDR=0.
REQ-023 Update inst 0x0000_1004, HIT=1, target 0x0000_2000; search 0x0000_1004 -> HIT=1, PREDICT=1, ADDR=0x0000_2000.
REQ-024 Then two updates HIT=0 same inst -> counter 2->1->0; search -> HIT=1, PREDICT=0, ADDR still 0x0000_2000; further HIT=0 keeps 0.
REQ-025 Allocate taken branches at 0x1004, 0x2004, 0x3004, 0x4004 (set 1), search 0x1004, then allocate 0x5004 -> 0x2004 evicted (search HIT=0), 0x1004 still HIT=1.
REQ-026 Update 0x6004 HIT=0 on miss -> no allocation; iFLUSH pulse -> all prior hits return HIT=0; search and update same set same cycle -> response shows old data, next search shows new.
